// File: rtl/adam_periph_apb_pause_gate_if.sv
// APB bus bundle used on both sides of the pause gate.
// The master modport drives the request; the slave modport returns the response.
interface adam_periph_apb_pause_gate_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/adam_periph_apb_pause_gate.sv
// APB pause gate: drains the in-flight transfer on a pause request, then blocks the
// target and acknowledges. Handshake: an APB transfer completes on psel&penable&pready.
module adam_periph_apb_pause_gate #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STALL_PAUSED  = 0,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int RST_PAUSED    = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pause_req,
    output logic                                pause_ack,
    adam_periph_apb_pause_gate_if.slave         slv,
    adam_periph_apb_pause_gate_if.master        mst,
    output logic                                drain_timeout,
    output logic [1:0]                          dbg_state
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    localparam int CW = (DRAIN_TIMEOUT < 1) ? 1 : $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(DRAIN_TIMEOUT);

    state_e          state_q, state_d;
    logic            ack_q, ack_d;
    logic            dto_q, dto_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            active_q, active_d;
    logic            post_rst_q;

    logic                    fwd;
    logic                    regen;
    logic                    complete;
    logic                    timeout_hit;
    logic [CW-1:0]           cnt_inc;
    logic                    mst_psel_c;
    logic                    mst_penable_c;
    logic [ADDR_WIDTH-1:0]   paddr_c;
    logic [DATA_WIDTH-1:0]   pwdata_c;
    logic [DATA_WIDTH/8-1:0] pstrb_c;
    logic [DATA_WIDTH-1:0]   prdata_c;
    logic                    pready_c;
    logic                    pslverr_c;

    always_comb begin
        fwd           = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !post_rst_q;
        // active_q means the target already saw the setup phase of the current transfer;
        // an upstream access without it gets a regenerated setup cycle first.
        regen         = slv.psel && slv.penable && !active_q;
        complete      = fwd && slv.psel && slv.penable && active_q && mst.pready;
        cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        timeout_hit   = (state_q == ST_DRAIN) && (DRAIN_TIMEOUT != 0) && pause_req &&
                        !complete && slv.psel && (cnt_inc >= TO_VAL);

        paddr_c       = slv.paddr;
        pwdata_c      = slv.pwdata;
        pstrb_c       = slv.pstrb;
        mst_psel_c    = 1'b0;
        mst_penable_c = 1'b0;
        prdata_c      = '0;
        pready_c      = 1'b0;
        pslverr_c     = 1'b0;

        if (timeout_hit) begin
            pready_c  = 1'b1;
            pslverr_c = 1'b1;
        end else if (fwd) begin
            mst_psel_c    = slv.psel;
            mst_penable_c = slv.penable && active_q;
            prdata_c      = mst.prdata;
            pready_c      = mst.pready && !regen;
            pslverr_c     = mst.pslverr && mst.pready && !regen;
        end else if ((state_q == ST_PAUSED) && (STALL_PAUSED == 0)) begin
            pready_c  = slv.psel && slv.penable;
            pslverr_c = slv.psel && slv.penable;
        end

        active_d = mst_psel_c && !(mst_penable_c && mst.pready);

        state_d = state_q;
        cnt_d   = cnt_q;
        dto_d   = dto_q;
        case (state_q)
            ST_RUN: begin
                if (pause_req) begin
                    if (slv.psel && !complete) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_inc;
                if (!pause_req) begin
                    state_d = ST_RUN;
                end else if (complete || !slv.psel) begin
                    state_d = ST_PAUSED;
                end else if (timeout_hit) begin
                    state_d = ST_PAUSED;
                    dto_d   = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (!pause_req) begin
                    state_d = ST_RUN;
                    dto_d   = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        ack_d = (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (RST_PAUSED != 0) ? ST_PAUSED : ST_RUN;
            ack_q      <= (RST_PAUSED != 0);
            dto_q      <= 1'b0;
            cnt_q      <= '0;
            active_q   <= 1'b0;
            post_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dto_q      <= dto_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            post_rst_q <= 1'b0;
        end
    end

    assign mst.psel      = mst_psel_c;
    assign mst.penable   = mst_penable_c;
    assign mst.pwrite    = slv.pwrite;
    assign mst.paddr     = paddr_c;
    assign mst.pwdata    = pwdata_c;
    assign mst.pstrb     = pstrb_c;
    assign slv.prdata    = prdata_c;
    assign slv.pready    = pready_c;
    assign slv.pslverr   = pslverr_c;

    assign pause_ack     = ack_q;
    assign drain_timeout = dto_q;
    assign dbg_state     = state_q;
endmodule
